// File: rtl/accum_unit.sv
`default_nettype none
// ============================================================================
//  Module   : accum_unit
//  Purpose  : WIDTH-bit accumulator with add, subtract, load and a DEPTH-deep
//             undo history. Reports unsigned carry/borrow and two's-complement
//             overflow of the last arithmetic op.
//
//  Ports
//    clk        in   rising-edge clock
//    rst        in   asynchronous, active-low reset
//    en         in   operation strobe, one op per clock edge while high
//    op         in   00 add, 01 sub, 10 load, 11 undo
//    in         in   WIDTH-bit operand
//    s          out  registered accumulator value
//    a          out  registered last operand (add/sub/load)
//    sum_wire   out  combinational preview of the next s for the current op
//    carry      out  registered carry (add) / borrow (sub)
//    overflow   out  registered signed overflow
//    hist_count out  number of valid history entries, 0..DEPTH
//    err        out  one-cycle pulse on undo with an empty history
//
//  Revision : 1.0  initial release
// ============================================================================
module accum_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum_wire,
  output logic             carry,
  output logic             overflow,
  output logic [CW-1:0]    hist_count,
  output logic             err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_OP_ADD  = 2'b00;
  localparam logic [1:0] c_OP_SUB  = 2'b01;
  localparam logic [1:0] c_OP_LOAD = 2'b10;
  localparam logic [1:0] c_OP_UNDO = 2'b11;

  // A single-entry history still needs a 1-bit pointer to stay legal.
  localparam int              c_PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(DEPTH - 1);
  localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
  localparam logic [CW-1:0]   c_CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]   c_CNT_ONE  = CW'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_a;
  logic             r_carry;
  logic             r_ovf;
  logic             r_err;
  logic [CW-1:0]    r_count;
  logic [c_PW-1:0]  r_wptr;
  logic [WIDTH-1:0] r_hist [DEPTH];

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_add_ext;
  logic [WIDTH:0]   w_sub_ext;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [c_PW-1:0]  w_top_ptr;
  logic [c_PW-1:0]  w_next_ptr;
  logic [WIDTH-1:0] w_top_val;
  logic             w_hist_empty;
  logic             w_push;
  logic             w_pop;

  // One extra bit carries the unsigned carry-out; for subtraction that bit
  // is set exactly when the true difference is negative, i.e. in > s.
  assign w_add_ext = {1'b0, r_s} + {1'b0, in};
  assign w_sub_ext = {1'b0, r_s} - {1'b0, in};

  assign w_add_ovf = (r_s[WIDTH-1] == in[WIDTH-1]) &&
                     (w_add_ext[WIDTH-1] != r_s[WIDTH-1]);
  assign w_sub_ovf = (r_s[WIDTH-1] != in[WIDTH-1]) &&
                     (w_sub_ext[WIDTH-1] != r_s[WIDTH-1]);

  // The write pointer always points one past the newest entry, so the top
  // of the history sits one slot behind it (with wrap-around).
  assign w_top_ptr  = (r_wptr == '0) ? c_PTR_LAST : (r_wptr - c_PTR_ONE);
  assign w_next_ptr = (r_wptr == c_PTR_LAST) ? '0 : (r_wptr + c_PTR_ONE);
  assign w_top_val  = r_hist[w_top_ptr];

  assign w_hist_empty = (r_count == '0);
  assign w_push       = en && (op != c_OP_UNDO);
  assign w_pop        = en && (op == c_OP_UNDO) && !w_hist_empty;

  // Preview ignores en so the display can show the pending result.
  always_comb begin
    sum_wire = r_s;
    case (op)
      c_OP_ADD:  sum_wire = w_add_ext[WIDTH-1:0];
      c_OP_SUB:  sum_wire = w_sub_ext[WIDTH-1:0];
      c_OP_LOAD: sum_wire = in;
      default:   sum_wire = w_hist_empty ? r_s : w_top_val;
    endcase
  end

  // --------------------------------------------------------------------------
  // Accumulator, operand and flag registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s     <= '0;
      r_a     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // err is a pulse: cleared unless this very edge is an empty undo.
      r_err <= 1'b0;
      if (en) begin
        case (op)
          c_OP_ADD: begin
            r_s     <= w_add_ext[WIDTH-1:0];
            r_a     <= in;
            r_carry <= w_add_ext[WIDTH];
            r_ovf   <= w_add_ovf;
          end
          c_OP_SUB: begin
            r_s     <= w_sub_ext[WIDTH-1:0];
            r_a     <= in;
            r_carry <= w_sub_ext[WIDTH];
            r_ovf   <= w_sub_ovf;
          end
          c_OP_LOAD: begin
            r_s     <= in;
            r_a     <= in;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
          end
          default: begin
            if (w_hist_empty) begin
              r_err <= 1'b1;
            end else begin
              r_s     <= w_top_val;
              r_carry <= 1'b0;
              r_ovf   <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // History bookkeeping: pointer and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= w_next_ptr;
        // When full the push silently replaces the oldest slot.
        if (r_count != c_CNT_FULL) begin
          r_count <= r_count + c_CNT_ONE;
        end
      end else if (w_pop) begin
        r_wptr  <= w_top_ptr;
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  // History storage carries no reset: an entry is only read once the
  // occupancy count says it has been written since the last reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_hist[r_wptr] <= r_s;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s          = r_s;
  assign a          = r_a;
  assign carry      = r_carry;
  assign overflow   = r_ovf;
  assign hist_count = r_count;
  assign err        = r_err;

endmodule
`default_nettype wire
